// File: rtl/jam_cost_table.sv
// ----------------------------------------------------------------------------
// jam_cost_table
//   Cost store for the JAM assignment solver. An 8x8 worker/job cost matrix
//   arrives row-major as a 64-word valid/ready stream. It is held in registers
//   and served combinationally on Cost for the solver's (W,J) lookups.
//   table_ready rises once the matrix is complete and releases the solver.
//
// Parameters
//   COST_W       width of one cost entry
//   IDX_W        width of the worker/job index; table holds (2**IDX_W)^2 entries
//
// Ports
//   CLK          clock, rising edge
//   RST_N        synchronous active-low reset
//   load_start   1-cycle pulse, begin (re)loading the table
//   in_valid     in_data holds a cost word
//   in_data      cost word; word k lands in entry {W,J} = k
//   in_ready     table accepts a word this cycle (high exactly while loading)
//   W, J         lookup indices from the solver
//   Cost         cost of (W,J), combinational, zero outside SERVE
//   table_ready  table fully loaded, lookups valid
//   load_cnt     words accepted in the current load
//   perr         (COST_PARITY_EN only) sticky parity error on a SERVE lookup
//
// Configuration
//   COST_PARITY_EN  when defined, each entry carries an even-parity bit and
//                   the perr output is present.
// ----------------------------------------------------------------------------
module jam_cost_table #(
    parameter int COST_W = 7,
    parameter int IDX_W  = 3
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 load_start,
    input  logic                 in_valid,
    input  logic [COST_W-1:0]    in_data,
    output logic                 in_ready,
    input  logic [IDX_W-1:0]     W,
    input  logic [IDX_W-1:0]     J,
    output logic [COST_W-1:0]    Cost,
    output logic                 table_ready,
    output logic [2*IDX_W-1:0]   load_cnt
`ifdef COST_PARITY_EN
    ,
    output logic                 perr
`endif
);

    localparam int AW    = 2 * IDX_W;
    localparam int DEPTH = 1 << AW;
`ifdef COST_PARITY_EN
    localparam int EW    = COST_W + 1;
`else
    localparam int EW    = COST_W;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SERVE
    } state_t;

    state_t            r_state;
    logic              r_in_ready;
    logic              r_table_ready;
    logic [AW-1:0]     r_load_cnt;
    logic [EW-1:0]     r_table [DEPTH];

    logic              w_xfer;
    logic              w_last;
    logic [EW-1:0]     w_wr_entry;
    logic [EW-1:0]     w_rd_entry;

    // r_in_ready is high exactly in LOAD; a load_start in the same cycle
    // restarts the load and discards the word.
    assign w_xfer = RST_N & in_valid & r_in_ready & ~load_start;
    assign w_last = (r_load_cnt == '1);

`ifdef COST_PARITY_EN
    // Even parity: stored bit makes the total count of ones even.
    assign w_wr_entry = {^in_data, in_data};
`else
    assign w_wr_entry = in_data;
`endif

    assign w_rd_entry = r_table[{W, J}];

    assign in_ready    = r_in_ready;
    assign table_ready = r_table_ready;
    assign load_cnt    = r_load_cnt;
    assign Cost        = r_table_ready ? w_rd_entry[COST_W-1:0] : '0;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state       <= S_IDLE;
            r_in_ready    <= 1'b0;
            r_table_ready <= 1'b0;
            r_load_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load_start) begin
                        r_state    <= S_LOAD;
                        r_in_ready <= 1'b1;
                        r_load_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (load_start) begin
                        r_load_cnt <= '0;
                    end else if (w_xfer) begin
                        if (w_last) begin
                            r_state       <= S_SERVE;
                            r_in_ready    <= 1'b0;
                            r_table_ready <= 1'b1;
                            r_load_cnt    <= '0;
                        end else begin
                            r_load_cnt <= r_load_cnt + 1'b1;
                        end
                    end
                end
                S_SERVE: begin
                    if (load_start) begin
                        r_state       <= S_LOAD;
                        r_in_ready    <= 1'b1;
                        r_table_ready <= 1'b0;
                        r_load_cnt    <= '0;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_in_ready    <= 1'b0;
                    r_table_ready <= 1'b0;
                    r_load_cnt    <= '0;
                end
            endcase
        end
    end

    // Storage is deliberately not reset; stale entries persist until overwritten.
    always_ff @(posedge CLK) begin
        if (w_xfer) begin
            r_table[r_load_cnt] <= w_wr_entry;
        end
    end

`ifdef COST_PARITY_EN
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            perr <= 1'b0;
        end else if (load_start) begin
            perr <= 1'b0;
        end else if (r_table_ready && (^w_rd_entry)) begin
            perr <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_jam_cost_table.sv
module tb_jam_cost_table;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       load_start = 1'b0;
    logic       in_valid = 1'b0;
    logic [6:0] in_data = '0;
    logic       in_ready;
    logic [2:0] W = '0;
    logic [2:0] J = '0;
    logic [6:0] Cost;
    logic       table_ready;
    logic [5:0] load_cnt;
`ifdef COST_PARITY_EN
    logic       perr;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a 64-entry array plus "loading" / "ready" flags and a word count.
    logic [6:0] m_mem [64];
    bit         m_loading = 0;
    bit         m_ready = 0;
    int         m_cnt = 0;

    jam_cost_table #(.COST_W(7), .IDX_W(3)) dut (
        .CLK(CLK), .RST_N(RST_N), .load_start(load_start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .W(W), .J(J), .Cost(Cost), .table_ready(table_ready),
        .load_cnt(load_cnt)
`ifdef COST_PARITY_EN
        , .perr(perr)
`endif
    );

    always #5 CLK = ~CLK;

    // One clock: advance the model with the inputs present at the edge, settle.
    task automatic cyc();
        @(posedge CLK);
        if (!RST_N) begin
            m_loading = 0; m_ready = 0; m_cnt = 0;
        end else if (load_start) begin
            m_loading = 1; m_ready = 0; m_cnt = 0;
        end else if (m_loading && in_valid) begin
            m_mem[m_cnt] = in_data;
            m_cnt++;
            if (m_cnt == 64) begin
                m_cnt = 0; m_loading = 0; m_ready = 1;
            end
        end
        #1;
    endtask

    function automatic logic [6:0] exp_cost(input logic [2:0] w, input logic [2:0] j);
        return m_ready ? m_mem[{w, j}] : 7'd0;
    endfunction

    task automatic test_reset();
        RST_N = 0; cyc(); cyc(); RST_N = 1;
        W = 3'd2; J = 3'd1; #1;
        n_vec++;
        if ({in_ready, table_ready, load_cnt, Cost} !== {1'b0, 1'b0, 6'd0, 7'd0}) begin
            n_err++;
            $display("FAIL reset: rdy=%b tr=%b cnt=%0d cost=%0d, want 0 0 0 0",
                     in_ready, table_ready, load_cnt, Cost);
        end
    endtask

    task automatic test_seq_load();
        load_start = 1; cyc(); load_start = 0;
        in_valid = 1;
        for (int k = 0; k < 64; k++) begin
            in_data = 7'(k);
            cyc();
            n_vec++;
            if ({in_ready, table_ready, load_cnt} !== {m_loading, m_ready, 6'(m_cnt)}) begin
                n_err++;
                $display("FAIL seq_load k=%0d: rdy=%b tr=%b cnt=%0d, want %b %b %0d",
                         k, in_ready, table_ready, load_cnt, m_loading, m_ready, m_cnt);
            end
        end
        in_valid = 0;
        W = 3'd3; J = 3'd5; #1;
        n_vec++;
        if (Cost !== 7'd29) begin
            n_err++;
            $display("FAIL seq_lookup_3_5: cost=%0d, want 29", Cost);
        end
        for (int i = 0; i < 16; i++) begin
            W = 3'($urandom); J = 3'($urandom); #1;
            n_vec++;
            if (Cost !== exp_cost(W, J)) begin
                n_err++;
                $display("FAIL seq_rand_lookup (%0d,%0d): cost=%0d, want %0d",
                         W, J, Cost, exp_cost(W, J));
            end
        end
    endtask

    task automatic test_toggle_load();
        int sent = 0;
        load_start = 1; cyc(); load_start = 0;
        for (int c = 0; c < 128; c++) begin
            in_valid = (c % 2 == 0);
            in_data = 7'(sent);
            cyc();
            if (in_valid) sent++;
            n_vec++;
            if ({in_ready, table_ready, load_cnt} !== {m_loading, m_ready, 6'(m_cnt)}) begin
                n_err++;
                $display("FAIL toggle_load c=%0d: rdy=%b tr=%b cnt=%0d, want %b %b %0d",
                         c, in_ready, table_ready, load_cnt, m_loading, m_ready, m_cnt);
            end
        end
        in_valid = 0;
        W = 3'd7; J = 3'd7; #1;
        n_vec++;
        if ({table_ready, Cost} !== {1'b1, 7'd63}) begin
            n_err++;
            $display("FAIL toggle_lookup_7_7: tr=%b cost=%0d, want 1 63", table_ready, Cost);
        end
        W = 3'd0; J = 3'd0; #1;
        n_vec++;
        if (Cost !== 7'd0) begin
            n_err++;
            $display("FAIL toggle_lookup_0_0: cost=%0d, want 0", Cost);
        end
    endtask

    task automatic test_random_load();
        int budget = 1000;
        load_start = 1; cyc(); load_start = 0;
        while (!m_ready && budget > 0) begin
            in_valid = 1'($urandom);
            in_data = 7'($urandom);
            cyc();
            budget--;
            n_vec++;
            if ({in_ready, table_ready, load_cnt} !== {m_loading, m_ready, 6'(m_cnt)}) begin
                n_err++;
                $display("FAIL rand_load: rdy=%b tr=%b cnt=%0d, want %b %b %0d",
                         in_ready, table_ready, load_cnt, m_loading, m_ready, m_cnt);
            end
        end
        in_valid = 0;
        n_vec++;
        if (budget == 0) begin
            n_err++;
            $display("FAIL rand_load_timeout: words=%0d, want 64", m_cnt);
        end
        for (int a = 0; a < 64; a++) begin
            {W, J} = 6'(a); #1;
            n_vec++;
            if (Cost !== exp_cost(W, J)) begin
                n_err++;
                $display("FAIL rand_lookup (%0d,%0d): cost=%0d, want %0d",
                         W, J, Cost, exp_cost(W, J));
            end
        end
    endtask

    task automatic test_restart();
        // Starts from SERVE: reload drops table_ready on the next cycle.
        load_start = 1; cyc(); load_start = 0;
        n_vec++;
        if ({table_ready, in_ready, load_cnt, Cost} !== {1'b0, 1'b1, 6'd0, 7'd0}) begin
            n_err++;
            $display("FAIL reload_from_serve: tr=%b rdy=%b cnt=%0d cost=%0d, want 0 1 0 0",
                     table_ready, in_ready, load_cnt, Cost);
        end
        in_valid = 1;
        for (int k = 0; k < 20; k++) begin
            in_data = 7'($urandom); cyc();
        end
        load_start = 1; in_data = 7'd55; cyc(); load_start = 0;
        n_vec++;
        if ({in_ready, load_cnt} !== {1'b1, 6'd0}) begin
            n_err++;
            $display("FAIL restart_cnt: rdy=%b cnt=%0d, want 1 0", in_ready, load_cnt);
        end
        in_data = 7'd100;
        for (int k = 0; k < 64; k++) begin
            cyc();
            n_vec++;
            if (table_ready !== (k == 63) || load_cnt !== 6'(m_cnt)) begin
                n_err++;
                $display("FAIL restart_load k=%0d: tr=%b cnt=%0d, want %b %0d",
                         k, table_ready, load_cnt, (k == 63), m_cnt);
            end
        end
        in_valid = 0;
        for (int a = 0; a < 64; a++) begin
            {W, J} = 6'(a); #1;
            n_vec++;
            if (Cost !== 7'd100) begin
                n_err++;
                $display("FAIL restart_lookup (%0d,%0d): cost=%0d, want 100", W, J, Cost);
            end
        end
    endtask

    task automatic test_mid_reset();
        load_start = 1; cyc(); load_start = 0;
        in_valid = 1;
        for (int k = 0; k < 40; k++) begin
            in_data = 7'($urandom); cyc();
        end
        n_vec++;
        if (load_cnt !== 6'd40) begin
            n_err++;
            $display("FAIL mid_reset_pre: cnt=%0d, want 40", load_cnt);
        end
        RST_N = 0; cyc(); RST_N = 1;
        W = 3'd5; J = 3'd2; #1;
        n_vec++;
        if ({in_ready, load_cnt, Cost, table_ready} !== {1'b0, 6'd0, 7'd0, 1'b0}) begin
            n_err++;
            $display("FAIL mid_reset: rdy=%b cnt=%0d cost=%0d tr=%b, want 0 0 0 0",
                     in_ready, load_cnt, Cost, table_ready);
        end
        for (int k = 0; k < 70; k++) begin
            in_data = 7'($urandom); cyc();
            n_vec++;
            if ({in_ready, table_ready, load_cnt} !== 8'd0) begin
                n_err++;
                $display("FAIL mid_reset_idle k=%0d: rdy=%b tr=%b cnt=%0d, want 0 0 0",
                         k, in_ready, table_ready, load_cnt);
            end
        end
        load_start = 1; cyc(); load_start = 0;
        for (int k = 0; k < 64; k++) begin
            in_data = ~7'(k); cyc();
        end
        in_valid = 0;
        W = 3'd6; J = 3'd1; #1;
        n_vec++;
        if ({table_ready, Cost} !== {1'b1, ~7'd49}) begin
            n_err++;
            $display("FAIL mid_reset_reload: tr=%b cost=%0d, want 1 %0d",
                     table_ready, Cost, ~7'd49);
        end
    endtask

    task automatic test_serve_ignore();
        in_valid = 1; in_data = 7'd127;
        for (int k = 0; k < 10; k++) begin
            cyc();
            n_vec++;
            if ({in_ready, table_ready} !== 2'b01) begin
                n_err++;
                $display("FAIL serve_ignore k=%0d: rdy=%b tr=%b, want 0 1",
                         k, in_ready, table_ready);
            end
        end
        in_valid = 0;
        for (int a = 0; a < 64; a++) begin
            {W, J} = 6'(a); #1;
            n_vec++;
            if (Cost !== exp_cost(W, J)) begin
                n_err++;
                $display("FAIL serve_ignore_lookup (%0d,%0d): cost=%0d, want %0d",
                         W, J, Cost, exp_cost(W, J));
            end
        end
    endtask

`ifdef COST_PARITY_EN
    task automatic test_parity();
        W = 3'd2; J = 3'd4; #1;
        n_vec++;
        if (perr !== 1'b0) begin
            n_err++;
            $display("FAIL parity_clean: perr=%b, want 0", perr);
        end
        dut.r_table[20] = dut.r_table[20] ^ 8'h01;
        cyc(); cyc(); W = 3'd0; J = 3'd0; cyc();
        n_vec++;
        if (perr !== 1'b1) begin
            n_err++;
            $display("FAIL parity_sticky: perr=%b, want 1", perr);
        end
        load_start = 1; cyc(); load_start = 0;
        n_vec++;
        if (perr !== 1'b0) begin
            n_err++;
            $display("FAIL parity_clear: perr=%b, want 0", perr);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_seq_load();
        test_toggle_load();
        test_random_load();
        test_restart();
        test_mid_reset();
        test_serve_ignore();
`ifdef COST_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
